quad_encoder_counter: RTL and testbench
=======================================

Name: quad_encoder_counter

Overview:
- Parametrised quadrature encoder interface. Next generation of the team's 2-bit incremental encoder block.
- Adds the following over the single-step plus/minus decoder:
  - input synchronisation and glitch filtering;
  - selectable x4/x2/x1 resolution;
  - a wrapping signed position counter with load and index-zeroing;
  - direction output;
  - illegal-transition error detection.
- Sits between the encoder pins (incA, incB, idx) and the motion-control/register logic.

Parameters:
- CNT_W, 16: position counter width (>=2).
- SYNC_STAGES, 2: synchroniser flops per input (>=2).
- FILT_LEN, 4: consecutive stable cycles required before a filtered input changes (>=1).
- MODE, 0: resolution. 0 = x4, 1 = x2, 2 = x1.
- IDX_EN, 1: 1 = index rising edge zeroes the position; 0 = idx is ignored.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- incA  in  1  encoder channel A, asynchronous pin
- incB  in  1  encoder channel B, asynchronous pin
- idx  in  1  encoder index pulse, asynchronous pin
- load  in  1  synchronous load strobe
- load_val  in  CNT_W  value written to pos on load
- err_clr  in  1  clears sticky err
- pos  out  CNT_W  position, two's complement, wraps
- plus1  out  1  one-cycle pulse on each counted forward step
- minus1  out  1  one-cycle pulse on each counted reverse step
- dir  out  1  last counted direction (1 = forward)
- err  out  1  sticky illegal-transition flag

Behaviour:
- Reset:
  - Single clock: clk. Reset: nrst, asynchronous assert, active-low.
  - While nrst=0, all flops clear immediately: sync chains, filter counters, filtered A/B/idx, previous A/B, pos=0, plus1=0, minus1=0, dir=0, err=0.
  - Reset mid-rotation discards any partial step.
  - After release, the first filtered state is taken as the reference. No count is generated from the reset value 00 unless the filtered inputs later change.
- Synchroniser: each input passes through SYNC_STAGES flops.
- Filter (per input):
  - Counter fc counts cycles where synced != filtered; fc resets to 0 whenever they are equal.
  - When synced != filtered and fc == FILT_LEN-1, filtered <= synced on that edge and fc <= 0.
  - Pulses shorter than FILT_LEN cycles are suppressed.
- Latency: a clean pin change sampled at edge 1 updates pos, plus1 and minus1 at edge SYNC_STAGES+FILT_LEN+1.
  - Defaults: 7 edges.
- Decode:
  - a = filtered A, b = filtered B; pa, pb = their values one cycle earlier.
  - Forward sequence (A,B): 00→01→11→10→00.
  - fwd = (pa^b) & ~(a^pb); rev = (a^pb) & ~(pa^b).
  - Both A and B changing in one cycle (bad = (a^pa)&(b^pb)): no count, err <= 1.
- Mode gating (plus1 and minus1 only pulse for counted steps):
  - x4: every fwd/rev step counts.
  - x2: only steps where A changes count.
  - x1: forward counts only 10→00; reverse counts only 00→10.
- Counter: pos <= pos+1 on counted fwd, pos-1 on counted rev, modulo 2^CNT_W.
  - Wrap cases: 0xFFFF+1 = 0x0000; 0x0000-1 = 0xFFFF.
  - dir <= 1 on a counted fwd step, 0 on a counted rev step; otherwise holds.
- Priority, same cycle:
  1. load: pos <= load_val. A concurrent step is dropped; plus1/minus1 still pulse; dir still updates.
  2. index: with IDX_EN=1, a filtered idx rising edge sets pos <= 0. Same drop rule as load.
  3. step.
- err:
  - err_clr clears err.
  - err_clr and bad in the same cycle leave err=1 (set wins).
  - err never affects counting.

Decomposition:
- Package quad_encoder_pkg:
  - MODE_X4=0, MODE_X2=1, MODE_X1=2 constants;
  - function for the filter counter width, clog2(FILT_LEN+1).
- Sub-module glitch_filter:
  - parameters SYNC_STAGES and FILT_LEN; ports clk, nrst, din, dout;
  - contains the synchroniser and the stability counter;
  - instantiated three times (A, B, idx).
- Decode, mode gating, counter and error logic live in the top module.

Test Plan (defaults unless stated):
- Reset, then 8 forward quadrature steps, each held 10 cycles → 8 plus1 pulses, pos=8, dir=1, err=0. Each pulse arrives 7 edges after the pin change.
- Set pos to 0x0001 via load, then 3 reverse steps → pos=0xFFFE, 3 minus1 pulses, dir=0.
- 3-cycle glitch on incA → no pulse, pos unchanged. 4-cycle hold → counted.
- MODE=1 with one full forward cycle → pos=+2. MODE=2 → pos=+1. Rocking 00↔10 five times in MODE=2 → net pos=0.
- A and B toggled together → err=1, pos unchanged. err_clr → err=0. err_clr concurrent with another simultaneous toggle → err stays 1.
- idx rising edge while pos=0x0123 and stepping forward → pos=0, plus1 pulse. Assert nrst mid-step → all outputs 0 immediately.

Source files
------------

// File: rtl/quad_encoder_pkg.sv
// Shared definitions for the quadrature encoder counter.
//   mode_e   : resolution selection (x4 / x2 / x1)
//   fc_width : width of the per-input filter stability counter
package quad_encoder_pkg;

  typedef enum logic [1:0] {
    MODE_X4 = 2'd0,
    MODE_X2 = 2'd1,
    MODE_X1 = 2'd2
  } mode_e;

  // Counter must be able to hold FILT_LEN-1; the +1 keeps FILT_LEN=1 at 1 bit.
  function automatic int unsigned fc_width(input int unsigned filt_len);
    return $clog2(filt_len + 1);
  endfunction

endpackage

// File: rtl/quad_encoder_counter_glitch_filter.sv
// Synchroniser plus stability filter for one asynchronous encoder pin.
//   clk  : clock
//   nrst : asynchronous active-low reset
//   din  : raw asynchronous pin
//   dout : synchronised, debounced level
// dout follows the synchronised input only after it has differed from dout
// for FILT_LEN consecutive cycles; shorter pulses are dropped.
module glitch_filter
  import quad_encoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic dout
);

  localparam int unsigned FC_W = fc_width(FILT_LEN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FC_W-1:0]        fc_q, fc_d;
  logic                   filt_q, filt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  always_comb begin
    fc_d   = '0;
    filt_d = filt_q;
    if (synced != filt_q) begin
      if (fc_q == FC_W'(FILT_LEN - 1)) begin
        filt_d = synced;
      end else begin
        fc_d = fc_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fc_q   <= '0;
      filt_q <= 1'b0;
    end else begin
      fc_q   <= fc_d;
      filt_q <= filt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder interface: filtered A/B/index inputs, x4/x2/x1 decode,
// wrapping signed position counter with load and index zeroing, direction
// and sticky illegal-transition error.
//   clk, nrst      : clock, asynchronous active-low reset
//   incA, incB     : encoder channels (asynchronous pins)
//   idx            : index pulse (asynchronous pin)
//   load, load_val : synchronous position load
//   err_clr        : clears sticky err
//   pos            : position, two's complement, wraps
//   plus1, minus1  : one-cycle pulse per counted forward / reverse step
//   dir            : last counted direction (1 = forward)
//   err            : sticky flag, A and B changed in the same cycle
module quad_encoder_counter
  import quad_encoder_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned MODE        = 0,
  parameter int unsigned IDX_EN      = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             incA,
  input  logic             incB,
  input  logic             idx,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             err_clr,
  output logic [CNT_W-1:0] pos,
  output logic             plus1,
  output logic             minus1,
  output logic             dir,
  output logic             err
);

  localparam mode_e MODE_SEL = mode_e'(MODE);

  logic a, b, ix;
  logic pa_q, pb_q, pix_q;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic plus_q, plus_d, minus_q, minus_d;
  logic dir_q, dir_d, err_q, err_d;
  logic fwd, rev, bad, cnt_fwd, cnt_rev, idx_rise;

  glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk (clk), .nrst(nrst), .din(incA), .dout(a)
  );
  glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk (clk), .nrst(nrst), .din(incB), .dout(b)
  );
  glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_idx (
    .clk (clk), .nrst(nrst), .din(idx), .dout(ix)
  );

  always_comb begin
    fwd      = (pa_q ^ b) & ~(a ^ pb_q);
    rev      = (a ^ pb_q) & ~(pa_q ^ b);
    bad      = (a ^ pa_q) & (b ^ pb_q);
    idx_rise = (IDX_EN != 0) && ix && !pix_q;

    cnt_fwd = 1'b0;
    cnt_rev = 1'b0;
    case (MODE_SEL)
      MODE_X4: begin
        cnt_fwd = fwd;
        cnt_rev = rev;
      end
      MODE_X2: begin
        cnt_fwd = fwd & (a ^ pa_q);
        cnt_rev = rev & (a ^ pa_q);
      end
      MODE_X1: begin
        // Only the 10<->00 edge of the cycle counts, in either direction.
        cnt_fwd = fwd & pa_q & ~pb_q & ~a & ~b;
        cnt_rev = rev & ~pa_q & ~pb_q & a & ~b;
      end
      default: begin
        cnt_fwd = 1'b0;
        cnt_rev = 1'b0;
      end
    endcase

    pos_d   = pos_q;
    plus_d  = cnt_fwd;
    minus_d = cnt_rev;
    dir_d   = dir_q;
    err_d   = err_q;

    if (cnt_fwd) begin
      dir_d = 1'b1;
    end else if (cnt_rev) begin
      dir_d = 1'b0;
    end

    // Load and index override the step but the step pulse still goes out.
    if (load) begin
      pos_d = load_val;
    end else if (idx_rise) begin
      pos_d = '0;
    end else if (cnt_fwd) begin
      pos_d = pos_q + CNT_W'(1);
    end else if (cnt_rev) begin
      pos_d = pos_q - CNT_W'(1);
    end

    if (bad) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pa_q    <= 1'b0;
      pb_q    <= 1'b0;
      pix_q   <= 1'b0;
      pos_q   <= '0;
      plus_q  <= 1'b0;
      minus_q <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pa_q    <= a;
      pb_q    <= b;
      pix_q   <= ix;
      pos_q   <= pos_d;
      plus_q  <= plus_d;
      minus_q <= minus_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign pos    = pos_q;
  assign plus1  = plus_q;
  assign minus1 = minus_q;
  assign dir    = dir_q;
  assign err    = err_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed bench for quad_encoder_counter: one instance per resolution mode,
// all driven from the same pins.
module tb_quad_encoder_counter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        incA = 1'b0, incB = 1'b0, idx = 1'b0;
  logic        load = 1'b0, err_clr = 1'b0;
  logic [15:0] load_val = '0;

  logic [15:0] pos4, pos2, pos1;
  logic        p4o, m4o, p2o, m2o, p1o, m1o;
  logic        dir4, dir2, dir1, err4, err2, err1;

  int nchecks = 0;
  int nerrors = 0;
  int p4, m4, p2, m2, p1, m1;

  always #5 clk = ~clk;

  quad_encoder_counter #(.CNT_W(16), .SYNC_STAGES(2), .FILT_LEN(4), .MODE(0), .IDX_EN(1)) u_x4 (
    .clk(clk), .nrst(nrst), .incA(incA), .incB(incB), .idx(idx), .load(load),
    .load_val(load_val), .err_clr(err_clr), .pos(pos4), .plus1(p4o), .minus1(m4o),
    .dir(dir4), .err(err4)
  );
  quad_encoder_counter #(.CNT_W(16), .SYNC_STAGES(2), .FILT_LEN(4), .MODE(1), .IDX_EN(1)) u_x2 (
    .clk(clk), .nrst(nrst), .incA(incA), .incB(incB), .idx(idx), .load(load),
    .load_val(load_val), .err_clr(err_clr), .pos(pos2), .plus1(p2o), .minus1(m2o),
    .dir(dir2), .err(err2)
  );
  quad_encoder_counter #(.CNT_W(16), .SYNC_STAGES(2), .FILT_LEN(4), .MODE(2), .IDX_EN(1)) u_x1 (
    .clk(clk), .nrst(nrst), .incA(incA), .incB(incB), .idx(idx), .load(load),
    .load_val(load_val), .err_clr(err_clr), .pos(pos1), .plus1(p1o), .minus1(m1o),
    .dir(dir1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    p4 = 0; m4 = 0; p2 = 0; m2 = 0; p1 = 0; m1 = 0;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      p4 += int'(p4o); m4 += int'(m4o);
      p2 += int'(p2o); m2 += int'(m2o);
      p1 += int'(p1o); m1 += int'(m1o);
    end
  endtask

  task automatic pins(input logic av, input logic bv);
    incA = av;
    incB = bv;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v;
    load = 1'b1;
    hold(1);
    load = 1'b0;
  endtask

  initial begin
    // Reset state
    clr_counts();
    hold(3);
    check("rst_pos", 32'(pos4), 32'h0);
    check("rst_plus1", 32'(p4o), 32'h0);
    check("rst_minus1", 32'(m4o), 32'h0);
    check("rst_dir", 32'(dir4), 32'h0);
    check("rst_err", 32'(err4), 32'h0);
    nrst = 1'b1;
    hold(10);

    // Eight forward steps: 00->01->11->10->00 twice
    clr_counts();
    pins(1'b0, 1'b1);
    hold(6);
    check("lat_no_pulse_e6", 32'(p4), 32'd0);
    hold(1);
    check("lat_pulse_e7", 32'(p4), 32'd1);
    check("lat_pos_e7", 32'(pos4), 32'd1);
    hold(3);
    pins(1'b1, 1'b1); hold(10);
    pins(1'b1, 1'b0); hold(10);
    pins(1'b0, 1'b0); hold(10);
    pins(1'b0, 1'b1); hold(10);
    pins(1'b1, 1'b1); hold(10);
    pins(1'b1, 1'b0); hold(10);
    pins(1'b0, 1'b0); hold(10);
    check("fwd_plus_cnt", 32'(p4), 32'd8);
    check("fwd_minus_cnt", 32'(m4), 32'd0);
    check("fwd_pos", 32'(pos4), 32'd8);
    check("fwd_dir", 32'(dir4), 32'd1);
    check("fwd_err", 32'(err4), 32'd0);
    check("fwd_x2_pos", 32'(pos2), 32'd4);
    check("fwd_x1_pos", 32'(pos1), 32'd2);

    // Load 1, then three reverse steps 00->10->11->01: wraps to 0xFFFE
    do_load(16'h0001);
    check("load_pos", 32'(pos4), 32'h0001);
    clr_counts();
    pins(1'b1, 1'b0); hold(10);
    pins(1'b1, 1'b1); hold(10);
    pins(1'b0, 1'b1); hold(10);
    check("rev_pos", 32'(pos4), 32'hFFFE);
    check("rev_minus_cnt", 32'(m4), 32'd3);
    check("rev_plus_cnt", 32'(p4), 32'd0);
    check("rev_dir", 32'(dir4), 32'd0);

    // Glitch on A: 3 cycles suppressed, 4 cycles passes (and returns)
    clr_counts();
    incA = 1'b1; hold(3); incA = 1'b0; hold(12);
    check("glitch3_plus", 32'(p4), 32'd0);
    check("glitch3_minus", 32'(m4), 32'd0);
    check("glitch3_pos", 32'(pos4), 32'hFFFE);
    clr_counts();
    incA = 1'b1; hold(4); incA = 1'b0; hold(14);
    check("glitch4_plus", 32'(p4), 32'd1);
    check("glitch4_minus", 32'(m4), 32'd1);
    check("glitch4_pos", 32'(pos4), 32'hFFFE);

    // Back to 00 (reverse), then resolution comparison from zero
    pins(1'b0, 1'b0); hold(10);
    do_load(16'h0000);
    clr_counts();
    pins(1'b0, 1'b1); hold(10);
    pins(1'b1, 1'b1); hold(10);
    pins(1'b1, 1'b0); hold(10);
    pins(1'b0, 1'b0); hold(10);
    check("mode_x4_pos", 32'(pos4), 32'd4);
    check("mode_x2_pos", 32'(pos2), 32'd2);
    check("mode_x1_pos", 32'(pos1), 32'd1);
    check("mode_x1_plus", 32'(p1), 32'd1);

    // Rocking 00<->10 five times
    clr_counts();
    repeat (5) begin
      pins(1'b1, 1'b0); hold(10);
      pins(1'b0, 1'b0); hold(10);
    end
    check("rock_x1_pos", 32'(pos1), 32'd1);
    check("rock_x1_plus", 32'(p1), 32'd5);
    check("rock_x1_minus", 32'(m1), 32'd5);
    check("rock_x4_pos", 32'(pos4), 32'd4);
    check("rock_x1_dir", 32'(dir1), 32'd1);

    // Simultaneous A/B toggle -> sticky err, no count
    clr_counts();
    pins(1'b1, 1'b1); hold(10);
    check("bad_err", 32'(err4), 32'd1);
    check("bad_pos", 32'(pos4), 32'd4);
    check("bad_pulses", 32'(p4 + m4), 32'd0);
    err_clr = 1'b1; hold(1); err_clr = 1'b0;
    check("errclr", 32'(err4), 32'd0);
    // err_clr lands on the very edge where the second bad transition decodes
    pins(1'b0, 1'b0); hold(6);
    check("pre_bad_err", 32'(err4), 32'd0);
    err_clr = 1'b1; hold(1); err_clr = 1'b0;
    check("bad_beats_clr", 32'(err4), 32'd1);
    hold(5);

    // Index rising edge together with a forward step
    do_load(16'h0123);
    check("idx_preload", 32'(pos4), 32'h0123);
    clr_counts();
    incB = 1'b1; idx = 1'b1;
    hold(7);
    check("idx_pos", 32'(pos4), 32'h0000);
    check("idx_plus", 32'(p4), 32'd1);
    check("idx_dir", 32'(dir4), 32'd1);
    idx = 1'b0; hold(10);
    check("idx_fall_pos", 32'(pos4), 32'h0000);

    // Asynchronous reset in the middle of a step
    do_load(16'h0005);
    incA = 1'b1;
    hold(3);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_pos", 32'(pos4), 32'h0);
    check("mid_rst_plus", 32'(p4o), 32'h0);
    check("mid_rst_minus", 32'(m4o), 32'h0);
    check("mid_rst_dir", 32'(dir4), 32'h0);
    check("mid_rst_err", 32'(err4), 32'h0);
    pins(1'b0, 1'b0);
    hold(4);
    nrst = 1'b1;
    clr_counts();
    hold(12);
    check("post_rst_pos", 32'(pos4), 32'h0);
    check("post_rst_err", 32'(err4), 32'h0);
    check("post_rst_pulses", 32'(p4 + m4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
